// File: rtl/dsp_ar_channel_pkg.sv
// Shared AXI4 interconnect widths and the layout of the read-order tracking entry.
package dsp_ar_channel_pkg;

   localparam int LEN_W   = 8;
   localparam int BURST_W = 2;
   localparam int SIZE_W  = 3;

   typedef enum logic [1:0] {
      AXI_BURST_FIXED = 2'b00,
      AXI_BURST_INCR  = 2'b01,
      AXI_BURST_WRAP  = 2'b10
   } axi_burst_e;

   // Order entry is {slave index, ARLEN}; slave index sits in the upper bits.
   function automatic int order_entry_w(input int slv_id_w, input int len_w);
      return slv_id_w + len_w;
   endfunction

endpackage

// File: rtl/dsp_ar_channel_fifo.sv
// Small synchronous first-word-fall-through FIFO; head data is valid whenever empty is low.
module dsp_ar_channel_fifo #(
   parameter int DATA_WIDTH = 9,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk_sys,
   input  logic                  rst_b,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  do_wr;
   logic                  do_rd;

   // Explicit wrap keeps non-power-of-two depths in range.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_wr   = wr_en & ~full;
   assign do_rd   = rd_en & ~empty;
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_wr) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_rd) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_wr, do_rd})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/dsp_ar_channel.sv
// Per-master AR dispatcher: decodes the target slave, registers the request toward it, and
// tracks outstanding bursts in order so the RDATA dispatcher knows which slave to listen to.
module dsp_ar_channel
   import dsp_ar_channel_pkg::*;
#(
   parameter int SLV_AMT            = 2,
   parameter int ADDR_WIDTH         = 32,
   parameter int TRANS_MST_ID_W     = 5,
   parameter int TRANS_BURST_W      = BURST_W,
   parameter int TRANS_DATA_LEN_W   = LEN_W,
   parameter int TRANS_DATA_SIZE_W  = SIZE_W,
   parameter int SLV_ID_W           = $clog2(SLV_AMT),
   parameter int DSP_AR_ORDER_DEPTH = 4
) (
   input  logic                         ACLK_i,
   input  logic                         ARESETn_i,
   input  logic [TRANS_MST_ID_W-1:0]    m_ARID_i,
   input  logic [ADDR_WIDTH-1:0]        m_ARADDR_i,
   input  logic [TRANS_BURST_W-1:0]     m_ARBURST_i,
   input  logic [TRANS_DATA_LEN_W-1:0]  m_ARLEN_i,
   input  logic [TRANS_DATA_SIZE_W-1:0] m_ARSIZE_i,
   input  logic                         m_ARVALID_i,
   output logic                         m_ARREADY_o,
   output logic [TRANS_MST_ID_W-1:0]    sa_ARID_o,
   output logic [ADDR_WIDTH-1:0]        sa_ARADDR_o,
   output logic [TRANS_BURST_W-1:0]     sa_ARBURST_o,
   output logic [TRANS_DATA_LEN_W-1:0]  sa_ARLEN_o,
   output logic [TRANS_DATA_SIZE_W-1:0] sa_ARSIZE_o,
   output logic [SLV_AMT-1:0]           sa_ARVALID_o,
   input  logic [SLV_AMT-1:0]           sa_ARREADY_i,
   input  logic                         dsp_RVALID_q1_i,
   input  logic                         dsp_RREADY_q1_i,
   output logic [SLV_ID_W-1:0]          dsp_AR_slv_id_o,
   output logic                         dsp_AR_disable_o
);

   localparam int ENTRY_W = order_entry_w(SLV_ID_W, TRANS_DATA_LEN_W);

   logic [SLV_ID_W-1:0]          slv_id;
   logic                         hold_vld;
   logic                         sa_hs;
   logic                         m_hs;
   logic                         r_hs;
   logic                         ar_ready;
   logic                         order_full;
   logic                         order_empty;
   logic                         order_pop;
   logic [ENTRY_W-1:0]           order_head;
   logic [SLV_ID_W-1:0]          head_slv;
   logic [TRANS_DATA_LEN_W-1:0]  head_len;

   logic [SLV_AMT-1:0]           hold_oh_q, hold_oh_d;
   logic [TRANS_MST_ID_W-1:0]    id_q, id_d;
   logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
   logic [TRANS_BURST_W-1:0]     burst_q, burst_d;
   logic [TRANS_DATA_LEN_W-1:0]  len_q, len_d;
   logic [TRANS_DATA_SIZE_W-1:0] size_q, size_d;
   logic [TRANS_DATA_LEN_W-1:0]  cnt_q, cnt_d;

   assign slv_id   = m_ARADDR_i[ADDR_WIDTH-1 -: SLV_ID_W];
   assign hold_vld = |hold_oh_q;
   assign sa_hs    = |(hold_oh_q & sa_ARREADY_i);
   // The holding slot can refill in the same cycle the slave takes it; a full order queue
   // blocks acceptance so no tracking entry is ever dropped.
   assign ar_ready = ARESETn_i & (~hold_vld | sa_hs) & ~order_full;
   assign m_hs     = m_ARVALID_i & ar_ready;

   always_comb begin
      hold_oh_d = hold_oh_q;
      id_d      = id_q;
      addr_d    = addr_q;
      burst_d   = burst_q;
      len_d     = len_q;
      size_d    = size_q;
      if (m_hs) begin
         for (int i = 0; i < SLV_AMT; i++) begin
            hold_oh_d[i] = (slv_id == SLV_ID_W'(i));
         end
         id_d    = m_ARID_i;
         addr_d  = m_ARADDR_i;
         burst_d = m_ARBURST_i;
         len_d   = m_ARLEN_i;
         size_d  = m_ARSIZE_i;
      end else if (sa_hs) begin
         hold_oh_d = '0;
      end
   end

   dsp_ar_channel_fifo #(
      .DATA_WIDTH (ENTRY_W),
      .FIFO_DEPTH (DSP_AR_ORDER_DEPTH)
   ) u_order_fifo (
      .clk_sys (ACLK_i),
      .rst_b   (ARESETn_i),
      .wr_en   (m_hs),
      .wr_data ({slv_id, m_ARLEN_i}),
      .rd_en   (order_pop),
      .rd_data (order_head),
      .full    (order_full),
      .empty   (order_empty)
   );

   assign head_slv = order_head[ENTRY_W-1 -: SLV_ID_W];
   assign head_len = order_head[TRANS_DATA_LEN_W-1:0];

   // Beats are only counted against a burst already at the head of the queue.
   assign r_hs      = dsp_RVALID_q1_i & dsp_RREADY_q1_i & ~order_empty;
   assign order_pop = r_hs & (cnt_q == head_len);

   always_comb begin
      cnt_d = cnt_q;
      if (order_pop) begin
         cnt_d = '0;
      end else if (r_hs) begin
         cnt_d = cnt_q + TRANS_DATA_LEN_W'(1);
      end
   end

   always_ff @(posedge ACLK_i) begin
      if (!ARESETn_i) begin
         hold_oh_q <= '0;
         id_q      <= '0;
         addr_q    <= '0;
         burst_q   <= '0;
         len_q     <= '0;
         size_q    <= '0;
         cnt_q     <= '0;
      end else begin
         hold_oh_q <= hold_oh_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         burst_q   <= burst_d;
         len_q     <= len_d;
         size_q    <= size_d;
         cnt_q     <= cnt_d;
      end
   end

   assign m_ARREADY_o      = ar_ready;
   assign sa_ARVALID_o     = hold_oh_q;
   assign sa_ARID_o        = id_q;
   assign sa_ARADDR_o      = addr_q;
   assign sa_ARBURST_o     = burst_q;
   assign sa_ARLEN_o       = len_q;
   assign sa_ARSIZE_o      = size_q;
   assign dsp_AR_disable_o = order_empty;
   assign dsp_AR_slv_id_o  = order_empty ? '0 : head_slv;

endmodule

// File: tb/tb_dsp_ar_channel.sv
// Bench for dsp_ar_channel: directed scenarios plus randomized traffic against a queue-based model.
module tb_dsp_ar_channel;

   localparam int DEPTH = 4;

   logic        ACLK_i = 1'b0;
   logic        ARESETn_i = 1'b0;
   logic [4:0]  m_ARID_i = '0;
   logic [31:0] m_ARADDR_i = '0;
   logic [1:0]  m_ARBURST_i = '0;
   logic [7:0]  m_ARLEN_i = '0;
   logic [2:0]  m_ARSIZE_i = '0;
   logic        m_ARVALID_i = 1'b0;
   logic        m_ARREADY_o;
   logic [4:0]  sa_ARID_o;
   logic [31:0] sa_ARADDR_o;
   logic [1:0]  sa_ARBURST_o;
   logic [7:0]  sa_ARLEN_o;
   logic [2:0]  sa_ARSIZE_o;
   logic [1:0]  sa_ARVALID_o;
   logic [1:0]  sa_ARREADY_i = '0;
   logic        dsp_RVALID_q1_i = 1'b0;
   logic        dsp_RREADY_q1_i = 1'b0;
   logic [0:0]  dsp_AR_slv_id_o;
   logic        dsp_AR_disable_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: outstanding bursts as queues, beats seen on the head burst, holding slot.
   int          q_slv[$];
   int          q_len[$];
   int          beats = 0;
   bit          mh_vld = 1'b0;
   int          mh_slv = 0;
   logic [4:0]  mh_id = '0;
   logic [31:0] mh_addr = '0;
   logic [1:0]  mh_burst = '0;
   logic [7:0]  mh_len = '0;
   logic [2:0]  mh_size = '0;

   dsp_ar_channel dut (
      .ACLK_i           (ACLK_i),
      .ARESETn_i        (ARESETn_i),
      .m_ARID_i         (m_ARID_i),
      .m_ARADDR_i       (m_ARADDR_i),
      .m_ARBURST_i      (m_ARBURST_i),
      .m_ARLEN_i        (m_ARLEN_i),
      .m_ARSIZE_i       (m_ARSIZE_i),
      .m_ARVALID_i      (m_ARVALID_i),
      .m_ARREADY_o      (m_ARREADY_o),
      .sa_ARID_o        (sa_ARID_o),
      .sa_ARADDR_o      (sa_ARADDR_o),
      .sa_ARBURST_o     (sa_ARBURST_o),
      .sa_ARLEN_o       (sa_ARLEN_o),
      .sa_ARSIZE_o      (sa_ARSIZE_o),
      .sa_ARVALID_o     (sa_ARVALID_o),
      .sa_ARREADY_i     (sa_ARREADY_i),
      .dsp_RVALID_q1_i  (dsp_RVALID_q1_i),
      .dsp_RREADY_q1_i  (dsp_RREADY_q1_i),
      .dsp_AR_slv_id_o  (dsp_AR_slv_id_o),
      .dsp_AR_disable_o (dsp_AR_disable_o)
   );

   always #5 ACLK_i = ~ACLK_i;

   function automatic logic exp_arready();
      return ARESETn_i && (!mh_vld || sa_ARREADY_i[mh_slv]) && (q_slv.size() < DEPTH);
   endfunction

   function automatic logic [1:0] exp_valid();
      return mh_vld ? 2'(1 << mh_slv) : 2'b00;
   endfunction

   function automatic logic exp_disable();
      return q_slv.size() == 0;
   endfunction

   function automatic logic [0:0] exp_slv();
      return (q_slv.size() == 0) ? 1'b0 : 1'(q_slv[0]);
   endfunction

   task automatic model_clk();
      bit mhs, shs, rhs;
      mhs = m_ARVALID_i && exp_arready();
      shs = mh_vld && sa_ARREADY_i[mh_slv];
      rhs = dsp_RVALID_q1_i && dsp_RREADY_q1_i && (q_slv.size() > 0);
      if (!ARESETn_i) begin
         q_slv.delete();
         q_len.delete();
         beats = 0; mh_vld = 1'b0; mh_slv = 0;
         mh_id = '0; mh_addr = '0; mh_burst = '0; mh_len = '0; mh_size = '0;
      end else begin
         if (rhs) begin
            if (beats == q_len[0]) begin
               void'(q_slv.pop_front());
               void'(q_len.pop_front());
               beats = 0;
            end else begin
               beats++;
            end
         end
         if (mhs) begin
            q_slv.push_back(int'(m_ARADDR_i[31]));
            q_len.push_back(int'(m_ARLEN_i));
            mh_vld = 1'b1; mh_slv = int'(m_ARADDR_i[31]);
            mh_id = m_ARID_i; mh_addr = m_ARADDR_i; mh_burst = m_ARBURST_i;
            mh_len = m_ARLEN_i; mh_size = m_ARSIZE_i;
         end else if (shs) begin
            mh_vld = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(posedge ACLK_i);
      model_clk();
      @(negedge ACLK_i);
   endtask

   task automatic set_ar(input logic v, input logic [31:0] a, input logic [7:0] l);
      m_ARVALID_i = v; m_ARADDR_i = a; m_ARLEN_i = l;
      m_ARID_i = 5'($urandom); m_ARBURST_i = 2'b01; m_ARSIZE_i = 3'b010;
   endtask

   task automatic set_r(input logic v);
      dsp_RVALID_q1_i = v; dsp_RREADY_q1_i = v;
   endtask

   task automatic drain();
      m_ARVALID_i = 1'b0; sa_ARREADY_i = 2'b11; set_r(1'b1);
      for (int g = 0; g < 1200 && (q_slv.size() > 0 || mh_vld); g++) tick();
      set_r(1'b0);
   endtask

   task automatic test_reset();
      ARESETn_i = 1'b0; set_ar(1'b1, 32'h8000_0040, 8'd5); sa_ARREADY_i = 2'b11; set_r(1'b1);
      for (int k = 0; k < 3; k++) begin
         tick(); #1;
         n_tests++;
         if (m_ARREADY_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_arready: got %b expected 0", m_ARREADY_o);
         end
      end
      ARESETn_i = 1'b1; m_ARVALID_i = 1'b0; set_r(1'b0); #1;
      n_tests++;
      if ({m_ARREADY_o, dsp_AR_disable_o, sa_ARVALID_o, dsp_AR_slv_id_o} !== 5'b11000) begin
         n_fail++; $display("FAIL reset_idle: got rdy/dis/vld/slv %b%b%b%b expected 11000",
                            m_ARREADY_o, dsp_AR_disable_o, sa_ARVALID_o, dsp_AR_slv_id_o);
      end
      n_tests++;
      if ({sa_ARID_o, sa_ARADDR_o, sa_ARBURST_o, sa_ARLEN_o, sa_ARSIZE_o} !== '0) begin
         n_fail++; $display("FAIL reset_payload: got addr %h len %h expected 0", sa_ARADDR_o, sa_ARLEN_o);
      end
      tick();
   endtask

   task automatic test_single();
      sa_ARREADY_i = 2'b11; set_r(1'b0); set_ar(1'b1, 32'h8000_0000, 8'd3); #1;
      n_tests++;
      if (m_ARREADY_o !== 1'b1) begin
         n_fail++; $display("FAIL single_arready: got %b expected 1", m_ARREADY_o);
      end
      tick(); m_ARVALID_i = 1'b0; #1;
      n_tests++;
      if ({sa_ARVALID_o, dsp_AR_slv_id_o, dsp_AR_disable_o} !== 4'b1010) begin
         n_fail++; $display("FAIL single_forward: got vld %b slv %b dis %b expected 10 1 0",
                            sa_ARVALID_o, dsp_AR_slv_id_o, dsp_AR_disable_o);
      end
      n_tests++;
      if (sa_ARADDR_o !== 32'h8000_0000 || sa_ARLEN_o !== 8'd3) begin
         n_fail++; $display("FAIL single_payload: got %h/%0d expected 80000000/3", sa_ARADDR_o, sa_ARLEN_o);
      end
      set_r(1'b1);
      for (int b = 1; b <= 4; b++) begin
         tick(); #1;
         n_tests++;
         if (dsp_AR_disable_o !== (b == 4)) begin
            n_fail++; $display("FAIL single_beat%0d: disable got %b expected %b", b, dsp_AR_disable_o, b == 4);
         end
      end
      set_r(1'b0);
   endtask

   task automatic test_stall();
      sa_ARREADY_i = 2'b10; set_r(1'b0);
      set_ar(1'b1, 32'h0000_1000, 8'd2); tick();
      set_ar(1'b1, 32'h0000_2000, 8'd1); #1;
      n_tests++;
      if (m_ARREADY_o !== 1'b0) begin
         n_fail++; $display("FAIL stall_arready: got %b expected 0", m_ARREADY_o);
      end
      for (int c = 0; c < 10; c++) begin
         tick(); #1;
         n_tests++;
         if ({m_ARREADY_o, sa_ARVALID_o, sa_ARADDR_o, sa_ARLEN_o} !== {1'b0, 2'b01, 32'h0000_1000, 8'd2}) begin
            n_fail++; $display("FAIL stall_hold%0d: got rdy %b vld %b addr %h len %0d expected 0 01 00001000 2",
                               c, m_ARREADY_o, sa_ARVALID_o, sa_ARADDR_o, sa_ARLEN_o);
         end
      end
      sa_ARREADY_i = 2'b11; #1;
      n_tests++;
      if (m_ARREADY_o !== 1'b1) begin
         n_fail++; $display("FAIL stall_release: got %b expected 1", m_ARREADY_o);
      end
      tick(); m_ARVALID_i = 1'b0; #1;
      n_tests++;
      if (sa_ARVALID_o !== 2'b01 || sa_ARADDR_o !== 32'h0000_2000) begin
         n_fail++; $display("FAIL stall_second: got vld %b addr %h expected 01 00002000", sa_ARVALID_o, sa_ARADDR_o);
      end
      drain(); #1;
      n_tests++;
      if (dsp_AR_disable_o !== 1'b1) begin
         n_fail++; $display("FAIL stall_drain: disable got %b expected 1", dsp_AR_disable_o);
      end
   endtask

   task automatic test_full();
      sa_ARREADY_i = 2'b11; set_r(1'b0);
      for (int k = 0; k < 5; k++) begin
         set_ar(1'b1, (k % 2 == 1) ? 32'h8000_0000 : 32'h0000_0000, 8'd0); #1;
         n_tests++;
         if (m_ARREADY_o !== (k < 4)) begin
            n_fail++; $display("FAIL full_ready%0d: got %b expected %b", k, m_ARREADY_o, k < 4);
         end
         tick();
      end
      set_r(1'b1); #1;
      n_tests++;
      if (m_ARREADY_o !== 1'b0) begin
         n_fail++; $display("FAIL full_pop_cycle: got %b expected 0", m_ARREADY_o);
      end
      tick(); set_r(1'b0); #1;
      n_tests++;
      if (m_ARREADY_o !== 1'b1 || dsp_AR_slv_id_o !== 1'b1) begin
         n_fail++; $display("FAIL full_after_pop: got rdy %b slv %b expected 1 1", m_ARREADY_o, dsp_AR_slv_id_o);
      end
      tick(); m_ARVALID_i = 1'b0; #1;
      n_tests++;
      if (m_ARREADY_o !== 1'b0 || q_slv.size() != DEPTH) begin
         n_fail++; $display("FAIL full_refilled: got rdy %b depth %0d expected 0 %0d", m_ARREADY_o, q_slv.size(), DEPTH);
      end
      drain();
   endtask

   task automatic test_interleave();
      sa_ARREADY_i = 2'b11; set_r(1'b0);
      set_ar(1'b1, 32'h0000_0100, 8'd1); tick();
      set_ar(1'b1, 32'h8000_0200, 8'd0); tick();
      m_ARVALID_i = 1'b0; set_r(1'b1); #1;
      for (int b = 0; b < 3; b++) begin
         n_tests++;
         if (dsp_AR_disable_o !== 1'b0 || dsp_AR_slv_id_o !== 1'(b == 2)) begin
            n_fail++; $display("FAIL interleave_beat%0d: got dis %b slv %b expected 0 %b",
                               b, dsp_AR_disable_o, dsp_AR_slv_id_o, b == 2);
         end
         tick(); #1;
      end
      n_tests++;
      if (dsp_AR_disable_o !== 1'b1) begin
         n_fail++; $display("FAIL interleave_done: disable got %b expected 1", dsp_AR_disable_o);
      end
      set_r(1'b0);
   endtask

   task automatic test_reset_mid();
      sa_ARREADY_i = 2'b11; set_r(1'b0);
      set_ar(1'b1, 32'h8000_0000, 8'd3); tick();
      m_ARVALID_i = 1'b0; set_r(1'b1); tick(); tick();
      ARESETn_i = 1'b0; set_r(1'b0); tick();
      ARESETn_i = 1'b1; #1;
      n_tests++;
      if (dsp_AR_disable_o !== 1'b1 || sa_ARVALID_o !== 2'b00 || dsp_AR_slv_id_o !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_clear: got dis %b vld %b slv %b expected 1 00 0",
                            dsp_AR_disable_o, sa_ARVALID_o, dsp_AR_slv_id_o);
      end
      set_ar(1'b1, 32'h0000_0000, 8'd1); tick();
      m_ARVALID_i = 1'b0; set_r(1'b1); #1;
      for (int b = 1; b <= 2; b++) begin
         tick(); #1;
         n_tests++;
         if (dsp_AR_disable_o !== (b == 2)) begin
            n_fail++; $display("FAIL rstmid_beat%0d: disable got %b expected %b", b, dsp_AR_disable_o, b == 2);
         end
      end
      set_r(1'b0);
   endtask

   task automatic test_len255();
      sa_ARREADY_i = 2'b11; set_r(1'b0);
      set_ar(1'b1, 32'h8000_0000, 8'd255); tick();
      m_ARVALID_i = 1'b0; set_r(1'b1);
      for (int b = 1; b <= 256; b++) begin
         tick(); #1;
         if (b >= 255) begin
            n_tests++;
            if (dsp_AR_disable_o !== (b == 256)) begin
               n_fail++; $display("FAIL len255_beat%0d: disable got %b expected %b", b, dsp_AR_disable_o, b == 256);
            end
         end
      end
      set_r(1'b0);
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         ARESETn_i       = ($urandom_range(0, 63) != 0);
         m_ARVALID_i     = 1'($urandom_range(0, 1));
         m_ARADDR_i      = $urandom;
         m_ARLEN_i       = 8'($urandom_range(0, 3));
         m_ARID_i        = 5'($urandom);
         m_ARBURST_i     = 2'($urandom);
         m_ARSIZE_i      = 3'($urandom);
         sa_ARREADY_i    = 2'($urandom_range(0, 3));
         dsp_RVALID_q1_i = 1'($urandom_range(0, 1));
         dsp_RREADY_q1_i = 1'($urandom_range(0, 1));
         #1;
         n_tests++;
         if (m_ARREADY_o !== exp_arready()) begin
            n_fail++; $display("FAIL rnd_arready c%0d: got %b expected %b", c, m_ARREADY_o, exp_arready());
         end
         n_tests++;
         if (sa_ARVALID_o !== exp_valid()) begin
            n_fail++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, sa_ARVALID_o, exp_valid());
         end
         n_tests++;
         if (dsp_AR_disable_o !== exp_disable() || dsp_AR_slv_id_o !== exp_slv()) begin
            n_fail++; $display("FAIL rnd_order c%0d: got dis %b slv %b expected %b %b",
                               c, dsp_AR_disable_o, dsp_AR_slv_id_o, exp_disable(), exp_slv());
         end
         n_tests++;
         if ({sa_ARID_o, sa_ARADDR_o, sa_ARBURST_o, sa_ARLEN_o, sa_ARSIZE_o} !==
             {mh_id, mh_addr, mh_burst, mh_len, mh_size}) begin
            n_fail++; $display("FAIL rnd_payload c%0d: got addr %h len %0d expected %h %0d",
                               c, sa_ARADDR_o, sa_ARLEN_o, mh_addr, mh_len);
         end
         tick();
      end
      ARESETn_i = 1'b1;
      drain(); #1;
      n_tests++;
      if (dsp_AR_disable_o !== 1'b1) begin
         n_fail++; $display("FAIL rnd_drain: disable got %b expected 1", dsp_AR_disable_o);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_stall();
      test_full();
      test_interleave();
      test_reset_mid();
      test_len255();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
